mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data word width in bits.
REQ-002 Parameter ADDR, default 3, SHALL set the address width in bits.
REQ-003 Parameter NREQ, default 4, SHALL set the number of requesters, with legal range 2..8.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-005 i_clk  in  1  SHALL be the single clock, sampled on its rising edge.
REQ-006 i_rst  in  1  SHALL be the synchronous active-high reset.
REQ-007 i_req  in  NREQ  SHALL be the per-requester access request.
REQ-008 i_we  in  NREQ  SHALL be the per-requester write flag, where 1 = write and 0 = read.
REQ-009 i_addr  in  NREQ*ADDR  SHALL carry the per-requester address, with requester k occupying slice [k*ADDR +: ADDR].
REQ-010 i_din  in  NREQ*WIDTH  SHALL carry the per-requester write data, with requester k occupying slice [k*WIDTH +: WIDTH].
REQ-011 o_gnt  out  NREQ  SHALL be the per-requester grant, asserted combinationally in the cycle of acceptance.
REQ-012 o_rvalid  out  NREQ  SHALL be the per-requester read-data-valid strobe.
REQ-013 o_rdata  out  NREQ*WIDTH  SHALL carry the per-requester read data, valid only when the matching o_rvalid bit is high.
REQ-014 o_en_a, o_we_a, o_addr_a, o_din_a  out  1/1/ADDR/WIDTH  SHALL drive memory port A.
REQ-015 i_dout_a  in  WIDTH  SHALL be the port A read data, registered by the memory one cycle after an enabled read.
REQ-016 o_en_b, o_we_b, o_addr_b, o_din_b, i_dout_b SHALL form port B, identical to port A.

Function
REQ-017 Handshake: a requester SHALL hold i_req, i_we, i_addr and i_din stable until it samples o_gnt high, and the transfer completes on that edge.
REQ-018 Port A selection SHALL grant the first requester with i_req set, searching upward from rr_ptr and wrapping modulo NREQ.
REQ-019 Port B selection SHALL grant the next requester with i_req set, searching upward from the port A winner + 1 and wrapping.
REQ-020 Port B SHALL never select the port A winner.
REQ-021 Conflict rule: if the A and B candidates have equal addresses and at least one is a write, port B SHALL be idle that cycle and the B candidate SHALL not be granted.
REQ-022 A read/read pair to the same address SHALL NOT be treated as a conflict, and both SHALL be granted.
REQ-023 Each granted requester SHALL drive its port: en=1, we=i_we[k], addr=that requester's address slice, din=that requester's data slice.
REQ-024 An ungranted port SHALL drive en=0, we=0, and zero on addr and din.
REQ-025 rr_ptr SHALL update on each cycle with at least one grant, to (highest-order granted index in search order) + 1 mod NREQ.
REQ-026 rr_ptr SHALL hold its value in a cycle with no requests.
REQ-027 Read tag: for each port, a registered valid bit plus requester index SHALL capture every granted read.
REQ-028 Read latency: o_rvalid[k] SHALL pulse for exactly 1 cycle, one cycle after the read grant, with o_rdata slice k = i_dout of the port that served it.
REQ-029 Writes SHALL produce no o_rvalid.
REQ-030 o_rdata slices SHALL be 0 when the matching o_rvalid bit is low.
REQ-031 Fairness: with all NREQ requesting continuously and no conflicts, every requester SHALL be granted at least once per ceil(NREQ/2) cycles.
REQ-032 With exactly one requester active, only port A SHALL be used.

Reset
REQ-033 While i_rst=1: o_gnt=0, o_en_a=o_en_b=0, o_we_a=o_we_b=0, o_rvalid=0, and o_rdata=0.
REQ-034 Reset SHALL load rr_ptr=0 and clear both read tags.
REQ-035 A read granted in the cycle before reset asserts SHALL be dropped, with no o_rvalid after reset releases.
REQ-036 The first cycle after reset release SHALL arbitrate normally from rr_ptr=0.

Structure
REQ-037 Package mem_arb_pkg SHALL hold the default NREQ constant, a typedef for the requester index (width $clog2(NREQ)), and a typedef for the read tag struct (valid, index).
REQ-038 Sub-module rr_pick SHALL provide the combinational first-set-at-or-after-pointer search, returning found and index, and SHALL be instantiated twice, once per port.
REQ-039 The block SHALL contain no storage of WIDTH data; read data SHALL route combinationally from i_dout via the registered tag.

Verification
REQ-040 Reset release with i_req=4'b0000 -> no grants, o_en_a=o_en_b=0, and rr_ptr remains 0.
REQ-041 i_req=4'b1111, all reads to distinct addresses, for 4 cycles -> grants in pairs {0,1},{2,3},{0,1},{2,3}, and o_rvalid follows each grant by 1 cycle with the correct data.
REQ-042 req0 write addr 3 data 8'hA5 plus req1 read addr 3 -> only req0 granted (port A), and req1 is granted the next cycle with o_rdata slice 1 = 8'hA5 one cycle later.
REQ-043 req2 and req3 both read addr 5 -> both granted in the same cycle, and both o_rvalid bits are high the next cycle with equal data.
REQ-044 req1 read granted, then i_rst=1 on the next edge -> o_rvalid stays 0, and after release req1 has no stale strobe.
REQ-045 Only req3 requesting, repeatedly -> port A only, one grant per cycle, and o_en_b stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: default requester count,
// requester index and the per-port read tag.
package mem_arb_pkg;

   localparam int NREQ_DEF = 4;
   localparam int NREQ_MAX = 8;

   // Index is sized for the largest legal requester count so any NREQ fits.
   typedef logic [$clog2(NREQ_MAX)-1:0] req_idx_t;

   typedef struct packed {
      logic     valid;
      req_idx_t idx;
   } rd_tag_t;

   function automatic req_idx_t wrap_inc(input req_idx_t i, input int n);
      return (int'(i) + 1 >= n) ? '0 : req_idx_t'(int'(i) + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after the
// pointer, wrapping modulo N.
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter int N = NREQ_DEF
) (
   input  logic [N-1:0] i_req,
   input  req_idx_t     i_ptr,
   output logic         o_found,
   output req_idx_t     o_idx
);

   logic [N-1:0] w_rot;
   int           w_pos;
   int           w_sum;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      w_pos   = 0;
      w_sum   = 0;
      w_rot   = N'({i_req, i_req} >> i_ptr);
      o_found = |i_req;
      for (int j = N - 1; j >= 0; j--) begin
         if (w_rot[j]) w_pos = j;
      end
      w_sum = int'(i_ptr) + w_pos;
      if (w_sum >= N) w_sum = w_sum - N;
      o_idx = req_idx_t'(w_sum);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates NREQ requesters onto two memory ports with round-robin fairness,
// same-address write conflict blocking and registered read-return tags.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ADDR  = 3,
   parameter int NREQ  = NREQ_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NREQ-1:0]       i_req,
   input  logic [NREQ-1:0]       i_we,
   input  logic [NREQ*ADDR-1:0]  i_addr,
   input  logic [NREQ*WIDTH-1:0] i_din,
   output logic [NREQ-1:0]       o_gnt,
   output logic [NREQ-1:0]       o_rvalid,
   output logic [NREQ*WIDTH-1:0] o_rdata,
   output logic                  o_en_a,
   output logic                  o_we_a,
   output logic [ADDR-1:0]       o_addr_a,
   output logic [WIDTH-1:0]      o_din_a,
   input  logic [WIDTH-1:0]      i_dout_a,
   output logic                  o_en_b,
   output logic                  o_we_b,
   output logic [ADDR-1:0]       o_addr_b,
   output logic [WIDTH-1:0]      o_din_b,
   input  logic [WIDTH-1:0]      i_dout_b
);

   req_idx_t         r_rr_ptr;
   rd_tag_t          r_tag_a, r_tag_b;

   logic             w_found_a, w_found_b;
   req_idx_t         w_idx_a, w_idx_b, w_ptr_b;
   logic [NREQ-1:0]  w_oh_a, w_oh_b, w_req_b;
   logic             w_we_a, w_we_b, w_conflict, w_gnt_a, w_gnt_b;
   logic [ADDR-1:0]  w_addr_a, w_addr_b;
   logic [WIDTH-1:0] w_din_a, w_din_b;

   rr_pick #(.N(NREQ)) u_pick_a (
      .i_req   (i_req),
      .i_ptr   (r_rr_ptr),
      .o_found (w_found_a),
      .o_idx   (w_idx_a)
   );

   // Port B never sees the port A winner and starts searching just past it.
   assign w_oh_a  = NREQ'(1) << w_idx_a;
   assign w_oh_b  = NREQ'(1) << w_idx_b;
   assign w_ptr_b = wrap_inc(w_idx_a, NREQ);
   assign w_req_b = w_found_a ? (i_req & ~w_oh_a) : '0;

   rr_pick #(.N(NREQ)) u_pick_b (
      .i_req   (w_req_b),
      .i_ptr   (w_ptr_b),
      .o_found (w_found_b),
      .o_idx   (w_idx_b)
   );

   always_comb begin
      w_we_a   = 1'b0;
      w_addr_a = '0;
      w_din_a  = '0;
      w_we_b   = 1'b0;
      w_addr_b = '0;
      w_din_b  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_idx_a == req_idx_t'(k)) begin
            w_we_a   = i_we[k];
            w_addr_a = i_addr[k*ADDR +: ADDR];
            w_din_a  = i_din[k*WIDTH +: WIDTH];
         end
         if (w_idx_b == req_idx_t'(k)) begin
            w_we_b   = i_we[k];
            w_addr_b = i_addr[k*ADDR +: ADDR];
            w_din_b  = i_din[k*WIDTH +: WIDTH];
         end
      end
   end

   // Same address with any write would make the result order-dependent; B yields.
   assign w_conflict = w_found_b && (w_addr_a == w_addr_b) && (w_we_a || w_we_b);
   assign w_gnt_a    = w_found_a && !i_rst;
   assign w_gnt_b    = w_found_b && !w_conflict && !i_rst;

   assign o_gnt    = (w_gnt_a ? w_oh_a : '0) | (w_gnt_b ? w_oh_b : '0);
   assign o_en_a   = w_gnt_a;
   assign o_we_a   = w_gnt_a && w_we_a;
   assign o_addr_a = w_gnt_a ? w_addr_a : '0;
   assign o_din_a  = w_gnt_a ? w_din_a : '0;
   assign o_en_b   = w_gnt_b;
   assign o_we_b   = w_gnt_b && w_we_b;
   assign o_addr_b = w_gnt_b ? w_addr_b : '0;
   assign o_din_b  = w_gnt_b ? w_din_b : '0;

   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (i_rst) begin
         r_rr_ptr <= '0;
         r_tag_a  <= '0;
         r_tag_b  <= '0;
      end else begin
         if (w_gnt_b)      r_rr_ptr <= wrap_inc(w_idx_b, NREQ);
         else if (w_gnt_a) r_rr_ptr <= wrap_inc(w_idx_a, NREQ);
         r_tag_a.valid <= w_gnt_a && !w_we_a;
         r_tag_a.idx   <= w_idx_a;
         r_tag_b.valid <= w_gnt_b && !w_we_b;
         r_tag_b.idx   <= w_idx_b;
      end
   end

   // Read data is never stored here; the tag steers the memory's registered output.
   always_comb begin
      o_rvalid = '0;
      o_rdata  = '0;
      if (!i_rst) begin
         for (int k = 0; k < NREQ; k++) begin
            if (r_tag_a.valid && r_tag_a.idx == req_idx_t'(k)) begin
               o_rvalid[k]                = 1'b1;
               o_rdata[k*WIDTH +: WIDTH]  = i_dout_a;
            end else if (r_tag_b.valid && r_tag_b.idx == req_idx_t'(k)) begin
               o_rvalid[k]                = 1'b1;
               o_rdata[k*WIDTH +: WIDTH]  = i_dout_b;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grants per cycle plus a
// scoreboard of read returns checked against a reference memory image.
module tb_mem_port_arbiter;

   localparam int W = 8;
   localparam int A = 3;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req, we;
   logic [N*A-1:0] addr;
   logic [N*W-1:0] din;
   logic [N-1:0]   gnt, rvalid;
   logic [N*W-1:0] rdata;
   logic           en_a, we_a, en_b, we_b;
   logic [A-1:0]   addr_a, addr_b;
   logic [W-1:0]   din_a, din_b, dout_a, dout_b;

   logic [W-1:0]   mem     [8];
   logic [W-1:0]   ref_mem [8];

   typedef struct {
      time        due;
      int         idx;
      logic [W-1:0] data;
   } rd_exp_t;

   rd_exp_t sb_q[$];
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WIDTH(W), .ADDR(A), .NREQ(N)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_req    (req),
      .i_we     (we),
      .i_addr   (addr),
      .i_din    (din),
      .o_gnt    (gnt),
      .o_rvalid (rvalid),
      .o_rdata  (rdata),
      .o_en_a   (en_a),
      .o_we_a   (we_a),
      .o_addr_a (addr_a),
      .o_din_a  (din_a),
      .i_dout_a (dout_a),
      .o_en_b   (en_b),
      .o_we_b   (we_b),
      .o_addr_b (addr_b),
      .o_din_b  (din_b),
      .i_dout_b (dout_b)
   );

   // Dual-port synchronous memory: read data registered one cycle after enable.
   always @(posedge clk) begin
      if (en_a) begin
         if (we_a) mem[addr_a] = din_a;
         else      dout_a <= mem[addr_a];
      end
      if (en_b) begin
         if (we_b) mem[addr_b] = din_b;
         else      dout_b <= mem[addr_b];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   task automatic idle();
      req  = '0;
      we   = '0;
      addr = '0;
      din  = '0;
   endtask

   task automatic set_req(input int k, input logic w, input logic [A-1:0] a, input logic [W-1:0] d);
      req[k]         = 1'b1;
      we[k]          = w;
      addr[k*A +: A] = a;
      din[k*W +: W]  = d;
   endtask

   // One clock cycle: check grants/port usage, update the reference image and
   // schedule expected read returns one cycle later.
   task automatic step(input logic [N-1:0] exp_gnt);
      logic [A-1:0] a;
      @(negedge clk);
      check("gnt",  32'(gnt),  32'(exp_gnt));
      check("en_a", 32'(en_a), 32'(|exp_gnt));
      check("en_b", 32'(en_b), 32'($countones(exp_gnt) == 2));
      for (int k = 0; k < N; k++) begin
         if (exp_gnt[k]) begin
            a = addr[k*A +: A];
            if (we[k]) ref_mem[a] = din[k*W +: W];
            else       sb_q.push_back('{due: $time + 10, idx: k, data: ref_mem[a]});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      rd_exp_t        e;
      logic [N-1:0]   exp_rv;
      logic [N*W-1:0] exp_rd;
      forever begin
         @(negedge clk);
         exp_rv = '0;
         exp_rd = '0;
         while (sb_q.size() > 0 && sb_q[0].due == $time) begin
            e = sb_q.pop_front();
            exp_rv[e.idx]          = 1'b1;
            exp_rd[e.idx*W +: W]   = e.data;
         end
         check("rvalid", 32'(rvalid), 32'(exp_rv));
         check("rdata",  32'(rdata),  32'(exp_rd));
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         mem[i]     = 8'h40 + 8'(i * 3);
         ref_mem[i] = 8'h40 + 8'(i * 3);
      end
      rst = 1'b1;
      idle();
      for (int k = 0; k < N; k++) set_req(k, 1'b0, 3'(k), 8'h00);
      fork
         monitor();
      join_none

      // Held in reset with everyone requesting: nothing may be granted.
      step(4'b0000);
      step(4'b0000);
      rst = 1'b0;
      idle();
      step(4'b0000);
      step(4'b0000);

      // All four reading distinct addresses: pairs rotate fairly.
      for (int k = 0; k < N; k++) set_req(k, 1'b0, 3'(k), 8'h00);
      step(4'b0011);
      step(4'b1100);
      step(4'b0011);
      step(4'b1100);

      // Write/read to the same address: the read waits and sees the new data.
      idle();
      set_req(0, 1'b1, 3'd3, 8'hA5);
      set_req(1, 1'b0, 3'd3, 8'h00);
      step(4'b0001);
      idle();
      set_req(1, 1'b0, 3'd3, 8'h00);
      step(4'b0010);

      // Read/read to the same address is not a conflict.
      idle();
      set_req(2, 1'b0, 3'd5, 8'h00);
      set_req(3, 1'b0, 3'd5, 8'h00);
      step(4'b1100);

      // Read granted, then reset: its return must be dropped.
      idle();
      set_req(1, 1'b0, 3'd6, 8'h00);
      step(4'b0010);
      rst = 1'b1;
      sb_q.delete();
      idle();
      step(4'b0000);
      step(4'b0000);
      rst = 1'b0;
      step(4'b0000);
      for (int k = 0; k < N; k++) set_req(k, 1'b0, 3'(k + 4), 8'h00);
      step(4'b0011);

      // Single requester uses port A only, including a write then read back.
      idle();
      set_req(3, 1'b0, 3'd7, 8'h00);
      step(4'b1000);
      set_req(3, 1'b0, 3'd6, 8'h00);
      step(4'b1000);
      set_req(3, 1'b1, 3'd2, 8'h5A);
      step(4'b1000);
      set_req(3, 1'b0, 3'd2, 8'h00);
      step(4'b1000);

      // Two writes on both ports, then cross reads through both ports.
      idle();
      set_req(0, 1'b1, 3'd0, 8'h11);
      set_req(1, 1'b1, 3'd1, 8'h22);
      step(4'b0011);
      idle();
      set_req(0, 1'b0, 3'd1, 8'h00);
      set_req(1, 1'b0, 3'd0, 8'h00);
      step(4'b0011);

      // Write/write to the same address: B candidate deferred, last write wins.
      idle();
      set_req(2, 1'b1, 3'd4, 8'h77);
      set_req(3, 1'b1, 3'd4, 8'h88);
      step(4'b0100);
      idle();
      set_req(3, 1'b1, 3'd4, 8'h88);
      step(4'b1000);
      idle();
      set_req(0, 1'b0, 3'd4, 8'h00);
      step(4'b0001);

      idle();
      step(4'b0000);
      step(4'b0000);
      check("drain", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
